// File: rtl/sea_de_ctrl.sv
// Iterative SEA decryption sequencer: one block in, NR reverse-key rounds through an external round datapath, one block out.
// Latency: NR+1 cycles from input accept to out_valid; one block per NR+2 cycles with out_ready held high.
// Backpressure: in_ready is low from accept until the output handshake completes; DONE holds data until out_ready.
module sea_de_ctrl #(
  parameter int NR         = 16,
  parameter int RW         = $clog2(NR),
  parameter bit FINAL_SWAP = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [47:0]   in_l,
  input  logic [47:0]   in_r,
  output logic [RW-1:0] key_idx,
  input  logic [47:0]   key_in,
  output logic [47:0]   rf_nl,
  output logic [47:0]   rf_nr,
  output logic [47:0]   rf_k,
  input  logic [47:0]   rf_l,
  input  logic [47:0]   rf_r,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [47:0]   out_l,
  output logic [47:0]   out_r,
  output logic          busy
);

  localparam logic [RW-1:0] RND_LAST = RW'(NR - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [47:0]   l_q, r_q, l_nxt, r_nxt;
  logic [RW-1:0] rnd, rnd_nxt;

  // Keys are consumed last-to-first, so the index counts down as rnd counts up.
  assign key_idx = RND_LAST - rnd;
  assign rf_nl   = l_q;
  assign rf_nr   = r_q;
  assign rf_k    = key_in;

  // in_ready is gated by rst so no block can slip in while the synchronous reset is still landing.
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);
  assign busy      = (state == S_RUN) || (state == S_DONE);
  assign out_l     = FINAL_SWAP ? r_q : l_q;
  assign out_r     = FINAL_SWAP ? l_q : r_q;

  // Next-state and datapath update selection; abort overrides every transition and leaves L/R alone.
  always_comb begin
    state_nxt = state;
    l_nxt     = l_q;
    r_nxt     = r_q;
    rnd_nxt   = rnd;
    if (abort) begin
      state_nxt = S_IDLE;
      rnd_nxt   = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            l_nxt     = in_l;
            r_nxt     = in_r;
            rnd_nxt   = '0;
            state_nxt = S_RUN;
          end
        end
        S_RUN: begin
          l_nxt = rf_l;
          r_nxt = rf_r;
          if (rnd == RND_LAST) begin
            rnd_nxt   = '0;
            state_nxt = S_DONE;
          end else begin
            rnd_nxt = rnd + RW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_nxt = S_IDLE;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          rnd_nxt   = '0;
        end
      endcase
    end
  end

  // State, half-block and round counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      l_q   <= '0;
      r_q   <= '0;
      rnd   <= '0;
    end else begin
      state <= state_nxt;
      l_q   <= l_nxt;
      r_q   <= r_nxt;
      rnd   <= rnd_nxt;
    end
  end

endmodule

// File: tb/tb_sea_de_ctrl.sv
// Bench for sea_de_ctrl: an NR=16 swapped instance and an NR=2 unswapped instance share clock and reset.
// Round stub is either "L+1, R" (directed cases) or a keyed mix (random cases) checked against a round-by-round model.
// All sampling and driving happen on the falling edge.
module tb_sea_de_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic keyed;
  int   checks = 0;
  int   errors = 0;

  logic [47:0] keys [16];

  // NR=16, FINAL_SWAP=1 instance
  logic        in_valid_a, in_ready_a, abort_a, out_valid_a, out_ready_a, busy_a;
  logic [47:0] in_l_a, in_r_a, key_in_a, rf_nl_a, rf_nr_a, rf_k_a, rf_l_a, rf_r_a, out_l_a, out_r_a;
  logic [3:0]  key_idx_a;

  // NR=2, FINAL_SWAP=0 instance
  logic        in_valid_b, in_ready_b, abort_b, out_valid_b, out_ready_b, busy_b;
  logic [47:0] in_l_b, in_r_b, key_in_b, rf_nl_b, rf_nr_b, rf_k_b, rf_l_b, rf_r_b, out_l_b, out_r_b;
  logic [0:0]  key_idx_b;

  always #5 clk = ~clk;

  assign key_in_a = keys[key_idx_a];
  assign key_in_b = keys[{3'b000, key_idx_b}];
  assign rf_l_a = keyed ? (rf_nr_a ^ rf_k_a) : (rf_nl_a + 48'd1);
  assign rf_r_a = keyed ? (rf_nl_a + rf_k_a) : rf_nr_a;
  assign rf_l_b = keyed ? (rf_nr_b ^ rf_k_b) : (rf_nl_b + 48'd1);
  assign rf_r_b = keyed ? (rf_nl_b + rf_k_b) : rf_nr_b;

  sea_de_ctrl #(.NR(16), .FINAL_SWAP(1'b1)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_l(in_l_a), .in_r(in_r_a), .key_idx(key_idx_a), .key_in(key_in_a),
    .rf_nl(rf_nl_a), .rf_nr(rf_nr_a), .rf_k(rf_k_a), .rf_l(rf_l_a), .rf_r(rf_r_a),
    .abort(abort_a), .out_valid(out_valid_a), .out_ready(out_ready_a),
    .out_l(out_l_a), .out_r(out_r_a), .busy(busy_a)
  );

  sea_de_ctrl #(.NR(2), .FINAL_SWAP(1'b0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_l(in_l_b), .in_r(in_r_b), .key_idx(key_idx_b), .key_in(key_in_b),
    .rf_nl(rf_nl_b), .rf_nr(rf_nr_b), .rf_k(rf_k_b), .rf_l(rf_l_b), .rf_r(rf_r_b),
    .abort(abort_b), .out_valid(out_valid_b), .out_ready(out_ready_b),
    .out_l(out_l_b), .out_r(out_r_b), .busy(busy_b)
  );

  // Reference: apply the stub round nr times with keys nr-1 down to 0, then the optional final swap.
  function automatic logic [95:0] model(input int nr, input bit swap, input logic [47:0] l0,
                                        input logic [47:0] r0, input bit kd);
    logic [47:0] l, r, k, t;
    l = l0;
    r = r0;
    for (int i = 0; i < nr; i++) begin
      k = keys[nr - 1 - i];
      if (kd) begin
        t = r ^ k;
        r = l + k;
        l = t;
      end else begin
        l = l + 48'd1;
      end
    end
    return swap ? {r, l} : {l, r};
  endfunction

  function automatic logic [47:0] rnd48();
    return {16'($urandom()), 32'($urandom())};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Presents a block to instance a for one cycle; returns in the first RUN cycle.
  task automatic accept_a(input logic [47:0] l, input logic [47:0] r);
    in_valid_a = 1'b1;
    in_l_a = l;
    in_r_a = r;
    tick();
    in_valid_a = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_a = 1'b1;
    in_valid_b = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
        errors++;
        $display("FAIL reset_in_ready cycle %0d: got a=%b b=%b want 0", c, in_ready_a, in_ready_b);
      end
    end
    rst = 1'b0;
    in_valid_a = 1'b0;
    in_valid_b = 1'b0;
    tick();
    checks++;
    if ({in_ready_a, out_valid_a, busy_a, key_idx_a} !== {1'b1, 1'b0, 1'b0, 4'd15}) begin
      errors++;
      $display("FAIL reset_ctrl_a: got rdy=%b vld=%b busy=%b idx=%0d want 1 0 0 15",
               in_ready_a, out_valid_a, busy_a, key_idx_a);
    end
    checks++;
    if ({out_l_a, out_r_a} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data_a: got %h/%h want 0/0", out_l_a, out_r_a);
    end
    checks++;
    if ({in_ready_b, out_valid_b, busy_b, key_idx_b} !== {1'b1, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_ctrl_b: got rdy=%b vld=%b busy=%b idx=%0d want 1 0 0 1",
               in_ready_b, out_valid_b, busy_b, key_idx_b);
    end
  endtask

  task automatic test_single();
    keyed = 1'b0;
    out_ready_a = 1'b1;
    checks++;
    if (in_ready_a !== 1'b1) begin
      errors++;
      $display("FAIL single_ready: got %b want 1", in_ready_a);
    end
    accept_a(48'h10, 48'hAB);
    for (int i = 0; i < 16; i++) begin
      checks++;
      if ({busy_a, out_valid_a, in_ready_a, key_idx_a} !== {1'b1, 1'b0, 1'b0, 4'(15 - i)}) begin
        errors++;
        $display("FAIL single_round %0d: got busy=%b vld=%b rdy=%b idx=%0d want 1 0 0 %0d",
                 i, busy_a, out_valid_a, in_ready_a, key_idx_a, 15 - i);
      end
      tick();
    end
    checks++;
    if ({out_valid_a, out_l_a, out_r_a} !== {1'b1, 48'hAB, 48'h20}) begin
      errors++;
      $display("FAIL single_out: got vld=%b %h/%h want 1 ab/20", out_valid_a, out_l_a, out_r_a);
    end
    tick();
    checks++;
    if ({out_valid_a, in_ready_a, busy_a} !== 3'b010) begin
      errors++;
      $display("FAIL single_after: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid_a, in_ready_a, busy_a);
    end
  endtask

  task automatic test_backpressure();
    logic [47:0] l2, r2;
    l2 = rnd48();
    r2 = rnd48();
    keyed = 1'b0;
    out_ready_a = 1'b0;
    accept_a(48'h10, 48'hAB);
    repeat (16) tick();
    in_valid_a = 1'b1;
    in_l_a = l2;
    in_r_a = r2;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({out_valid_a, in_ready_a, out_l_a, out_r_a} !== {1'b1, 1'b0, 48'hAB, 48'h20}) begin
        errors++;
        $display("FAIL bp_hold cycle %0d: got vld=%b rdy=%b %h/%h want 1 0 ab/20",
                 c, out_valid_a, in_ready_a, out_l_a, out_r_a);
      end
      tick();
    end
    out_ready_a = 1'b1;
    tick();
    checks++;
    if ({out_valid_a, in_ready_a, busy_a} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid_a, in_ready_a, busy_a);
    end
    tick();
    in_valid_a = 1'b0;
    checks++;
    if ({busy_a, key_idx_a} !== {1'b1, 4'd15}) begin
      errors++;
      $display("FAIL bp_second_accept: got busy=%b idx=%0d want 1 15", busy_a, key_idx_a);
    end
    repeat (16) tick();
    checks++;
    if ({out_valid_a, out_l_a, out_r_a} !== {1'b1, model(16, 1'b1, l2, r2, 1'b0)}) begin
      errors++;
      $display("FAIL bp_second_out: got vld=%b %h/%h want 1 %h", out_valid_a, out_l_a, out_r_a,
               model(16, 1'b1, l2, r2, 1'b0));
    end
    tick();
  endtask

  task automatic test_abort_mid();
    logic [47:0] l1, r1;
    int seen;
    l1 = rnd48() & 48'h7FFF_FFFF_FFFF;
    r1 = rnd48();
    keyed = 1'b0;
    out_ready_a = 1'b1;
    accept_a(l1, r1);
    repeat (7) tick();
    checks++;
    if (key_idx_a !== 4'd8) begin
      errors++;
      $display("FAIL abort_idx: got %0d want 8", key_idx_a);
    end
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    checks++;
    if ({in_ready_a, busy_a, out_valid_a} !== 3'b100) begin
      errors++;
      $display("FAIL abort_idle: got rdy=%b busy=%b vld=%b want 1 0 0", in_ready_a, busy_a, out_valid_a);
    end
    checks++;
    if ({out_l_a, out_r_a} !== {r1, l1 + 48'd7}) begin
      errors++;
      $display("FAIL abort_hold_lr: got %h/%h want %h/%h", out_l_a, out_r_a, r1, l1 + 48'd7);
    end
    seen = 0;
    repeat (20) begin
      if (out_valid_a !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_output: got %0d valid cycles want 0", seen);
    end
    accept_a(48'h10, 48'hAB);
    repeat (16) tick();
    checks++;
    if ({out_valid_a, out_l_a, out_r_a} !== {1'b1, 48'hAB, 48'h20}) begin
      errors++;
      $display("FAIL abort_next_out: got vld=%b %h/%h want 1 ab/20", out_valid_a, out_l_a, out_r_a);
    end
    tick();
  endtask

  task automatic test_abort_priority();
    keyed = 1'b0;
    out_ready_a = 1'b0;
    accept_a(rnd48(), rnd48());
    repeat (16) tick();
    checks++;
    if (out_valid_a !== 1'b1) begin
      errors++;
      $display("FAIL prio_done: got vld=%b want 1", out_valid_a);
    end
    out_ready_a = 1'b1;
    abort_a = 1'b1;
    tick();
    checks++;
    if ({out_valid_a, in_ready_a, busy_a} !== 3'b010) begin
      errors++;
      $display("FAIL prio_done_abort: got vld=%b rdy=%b busy=%b want 0 1 0", out_valid_a, in_ready_a, busy_a);
    end
    in_valid_a = 1'b1;
    in_l_a = 48'h10;
    in_r_a = 48'hAB;
    tick();
    checks++;
    if ({busy_a, in_ready_a} !== 2'b01) begin
      errors++;
      $display("FAIL prio_idle_abort: got busy=%b rdy=%b want 0 1", busy_a, in_ready_a);
    end
    abort_a = 1'b0;
    tick();
    in_valid_a = 1'b0;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL prio_accept_after: got busy=%b want 1", busy_a);
    end
    out_ready_a = 1'b0;
    repeat (16) tick();
    abort_a = 1'b1;
    tick();
    abort_a = 1'b0;
    checks++;
    if ({out_valid_a, in_ready_a} !== 2'b01) begin
      errors++;
      $display("FAIL prio_abort_stalled: got vld=%b rdy=%b want 0 1", out_valid_a, in_ready_a);
    end
    out_ready_a = 1'b1;
  endtask

  task automatic test_random();
    logic [47:0] l, r;
    logic [95:0] exp;
    keyed = 1'b1;
    for (int n = 0; n < 8; n++) begin
      for (int k = 0; k < 16; k++) keys[k] = rnd48();
      l = rnd48();
      r = rnd48();
      exp = model(16, 1'b1, l, r, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
      accept_a(l, r);
      repeat (16) tick();
      out_ready_a = 1'b0;
      repeat ($urandom_range(0, 3)) begin
        checks++;
        if ({out_valid_a, out_l_a, out_r_a} !== {1'b1, exp}) begin
          errors++;
          $display("FAIL rand_stall blk %0d: got vld=%b %h/%h want 1 %h", n, out_valid_a, out_l_a, out_r_a, exp);
        end
        tick();
      end
      out_ready_a = 1'b1;
      checks++;
      if ({out_valid_a, out_l_a, out_r_a} !== {1'b1, exp}) begin
        errors++;
        $display("FAIL rand_out blk %0d: got vld=%b %h/%h want 1 %h", n, out_valid_a, out_l_a, out_r_a, exp);
      end
      tick();
    end
  endtask

  task automatic test_corner();
    logic [47:0] l, r;
    logic [95:0] exp;
    keyed = 1'b0;
    out_ready_b = 1'b1;
    in_valid_b = 1'b1;
    in_l_b = 48'h10;
    in_r_b = 48'hAB;
    tick();
    in_valid_b = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({busy_b, out_valid_b, key_idx_b} !== {1'b1, 1'b0, 1'(1 - i)}) begin
        errors++;
        $display("FAIL corner_round %0d: got busy=%b vld=%b idx=%0d want 1 0 %0d",
                 i, busy_b, out_valid_b, key_idx_b, 1 - i);
      end
      tick();
    end
    checks++;
    if ({out_valid_b, out_l_b, out_r_b} !== {1'b1, 48'h12, 48'hAB}) begin
      errors++;
      $display("FAIL corner_out: got vld=%b %h/%h want 1 12/ab", out_valid_b, out_l_b, out_r_b);
    end
    tick();
    keyed = 1'b1;
    keys[0] = rnd48();
    keys[1] = rnd48();
    l = rnd48();
    r = rnd48();
    exp = model(2, 1'b0, l, r, 1'b1);
    in_valid_b = 1'b1;
    in_l_b = l;
    in_r_b = r;
    tick();
    in_valid_b = 1'b0;
    repeat (2) tick();
    checks++;
    if ({out_valid_b, out_l_b, out_r_b} !== {1'b1, exp}) begin
      errors++;
      $display("FAIL corner_keyed: got vld=%b %h/%h want 1 %h", out_valid_b, out_l_b, out_r_b, exp);
    end
    tick();
  endtask

  initial begin
    keyed = 1'b0;
    for (int k = 0; k < 16; k++) keys[k] = 48'd0;
    in_valid_a = 1'b0; in_l_a = '0; in_r_a = '0; abort_a = 1'b0; out_ready_a = 1'b1;
    in_valid_b = 1'b0; in_l_b = '0; in_r_b = '0; abort_b = 1'b0; out_ready_b = 1'b1;
    test_reset();
    test_single();
    test_backpressure();
    test_abort_mid();
    test_abort_priority();
    test_random();
    test_corner();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
